// File: rtl/sqrt_seq_ctrl.sv
// Control sequencer for the odd-number-sum square-root datapath (Moore FSM).
// Optional status ports iter/capped are enabled with SQRT_SEQ_CTRL_STATUS_EN.
module sqrt_seq_ctrl #(
  parameter int WIDTH    = 8,
  parameter int MAX_ITER = 2**(WIDTH/2)-1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Go,
  input  logic             B0,
  output logic             over,
  output logic             busy,
  output logic [5:0]       fnselect,
  output logic             TSW,
  output logic             Tval,
  output logic             Tsqrt,
  output logic             Tsum,
  output logic             ldsqrt,
  output logic             ldsum,
  output logic             ldval
`ifdef SQRT_SEQ_CTRL_STATUS_EN
  ,
  output logic [WIDTH/2-1:0] iter,
  output logic             capped
`endif
);
  localparam int IW = WIDTH/2;
  localparam logic [IW-1:0] CAP = IW'(MAX_ITER);

  localparam logic [5:0] FN_ZERO = 6'b000001;
  localparam logic [5:0] FN_ADD  = 6'b000010;
  localparam logic [5:0] FN_SUB  = 6'b000100;
  localparam logic [5:0] FN_ONE  = 6'b001000;
  localparam logic [5:0] FN_XP2  = 6'b010000;
  localparam logic [5:0] FN_YP1  = 6'b100000;

  typedef enum logic [3:0] {
    S_IDLE, S_INIT_SQRT, S_INIT_VAL, S_INIT_SUM, S_COMPARE,
    S_INC_SQRT, S_INC_VAL, S_ADD_SUM, S_DONE
  } state_t;

  state_t        state, state_nx;
  logic [IW-1:0] iter_cnt;
  logic          cap_hit;

  // Cap check wins over B0: once sum has wrapped, the sign status is garbage.
  assign cap_hit = (iter_cnt == CAP);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      iter_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == S_INIT_SQRT)    iter_cnt <= '0;
      else if (state == S_ADD_SUM) iter_cnt <= iter_cnt + IW'(1);
    end
  end

  always_comb begin
    state_nx = state;
    fnselect = '0;
    {TSW, Tval, Tsqrt, Tsum}  = '0;
    {ldsqrt, ldsum, ldval}    = '0;
    over = 1'b0;
    busy = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (Go) state_nx = S_INIT_SQRT;
      end
      S_INIT_SQRT: begin
        fnselect = FN_ZERO; ldsqrt = 1'b1; state_nx = S_INIT_VAL;
      end
      S_INIT_VAL: begin
        fnselect = FN_ONE; ldval = 1'b1; state_nx = S_INIT_SUM;
      end
      S_INIT_SUM: begin
        fnselect = FN_ONE; ldsum = 1'b1; state_nx = S_COMPARE;
      end
      S_COMPARE: begin
        fnselect = FN_SUB; TSW = 1'b1; Tsum = 1'b1;
        state_nx = (B0 || cap_hit) ? S_DONE : S_INC_SQRT;
      end
      S_INC_SQRT: begin
        fnselect = FN_YP1; Tsqrt = 1'b1; ldsqrt = 1'b1; state_nx = S_INC_VAL;
      end
      S_INC_VAL: begin
        fnselect = FN_XP2; Tval = 1'b1; ldval = 1'b1; state_nx = S_ADD_SUM;
      end
      S_ADD_SUM: begin
        fnselect = FN_ADD; Tval = 1'b1; Tsum = 1'b1; ldsum = 1'b1;
        state_nx = S_COMPARE;
      end
      S_DONE: begin
        busy = 1'b0; over = 1'b1;
        if (!Go) state_nx = S_IDLE;
      end
      default: begin
        busy = 1'b0; state_nx = S_IDLE;
      end
    endcase
  end

`ifdef SQRT_SEQ_CTRL_STATUS_EN
  assign iter = iter_cnt;

  always_ff @(posedge clk) begin
    if (!reset)                                     capped <= 1'b0;
    else if (state == S_INIT_SQRT)                  capped <= 1'b0;
    else if (state == S_COMPARE && cap_hit && !B0)  capped <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_sqrt_seq_ctrl.sv
// Bench for sqrt_seq_ctrl: a behavioural datapath closes the loop, results
// are checked against arithmetic floor(sqrt(n)) and the algorithm's op sequence.
module tb_sqrt_seq_ctrl;
  localparam int W    = 8;
  localparam int IW   = W/2;
  localparam int MAXI = 2**IW-1;

  logic clk = 1'b0, reset = 1'b0, Go = 1'b0, B0;
  logic over, busy, TSW, Tval, Tsqrt, Tsum, ldsqrt, ldsum, ldval;
  logic [5:0] fnselect;
`ifdef SQRT_SEQ_CTRL_STATUS_EN
  logic [IW-1:0] iter;
  logic          capped;
`endif

  sqrt_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .Go(Go), .B0(B0), .over(over), .busy(busy),
    .fnselect(fnselect), .TSW(TSW), .Tval(Tval), .Tsqrt(Tsqrt), .Tsum(Tsum),
    .ldsqrt(ldsqrt), .ldsum(ldsum), .ldval(ldval)
`ifdef SQRT_SEQ_CTRL_STATUS_EN
    , .iter(iter), .capped(capped)
`endif
  );

  always #5 clk = ~clk;

  // datapath: shared ALU over X/Y buses plus the three registers
  logic [W-1:0] n = '0, sqrt_r = '0, val_r = '0, sum_r = '0;
  logic [W-1:0] xb, yb, alu;
  logic [W:0]   diff;

  always_comb begin
    xb = TSW ? n : (Tval ? val_r : '0);
    yb = Tsqrt ? sqrt_r : (Tsum ? sum_r : '0);
    diff = {1'b0, xb} - {1'b0, yb};
    alu = '0;
    case (fnselect)
      6'b000001: alu = '0;
      6'b000010: alu = xb + yb;
      6'b000100: alu = diff[W-1:0];
      6'b001000: alu = W'(1);
      6'b010000: alu = xb + W'(2);
      6'b100000: alu = yb + W'(1);
      default:   alu = '0;
    endcase
  end
  assign B0 = diff[W];

  always @(posedge clk) begin
    if (ldsqrt) sqrt_r <= alu;
    if (ldval)  val_r  <= alu;
    if (ldsum)  sum_r  <= alu;
  end

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int ref_k(input int nv);
    int k = 0;
    while ((k+1)*(k+1) <= nv && k < MAXI) k++;
    return k;
  endfunction

  task automatic idle_chk(input string tag);
    chk({tag, "_fn"}, fnselect, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_over"}, over, 0);
    chk({tag, "_sel"}, {TSW, Tval, Tsqrt, Tsum, ldsqrt, ldsum, ldval}, 0);
  endtask

  // Go rises before E0; sample each cycle at the negedge after E_c.
  task automatic run(input int nv, input int hold, input int drop_at);
    int k, len, lds;
    bit seen;
    logic [5:0] exp_q[$];
    k   = ref_k(nv);
    len = 4 + 4*k;
    exp_q.delete();
    exp_q.push_back(6'b000001); exp_q.push_back(6'b001000); exp_q.push_back(6'b001000);
    for (int i = 0; i < k; i++) begin
      exp_q.push_back(6'b000100); exp_q.push_back(6'b100000);
      exp_q.push_back(6'b010000); exp_q.push_back(6'b000010);
    end
    exp_q.push_back(6'b000100);
    n = nv[W-1:0];
    @(negedge clk) Go = 1'b1;
    lds = 0; seen = 0;
    for (int c = 0; c < len + 8 && !seen; c++) begin
      @(negedge clk);
      if (over) begin
        seen = 1;
        chk("latency", c, len);
      end else begin
        if (c < len) chk("fnseq", fnselect, exp_q[c]);
        chk("busy_run", busy, 1);
        chk("onehot", {$onehot0({ldsqrt, ldsum, ldval}), $onehot0({TSW, Tval}),
                       $onehot0({Tsqrt, Tsum})}, 3'b111);
        lds += int'(ldsum);
      end
      if (c == drop_at) Go = 1'b0;
    end
    if (!seen) chk("over_timeout", 0, 1);
    chk("sqrt", sqrt_r, k);
    chk("ldsum_cnt", lds, k + 1);
`ifdef SQRT_SEQ_CTRL_STATUS_EN
    chk("iter", iter, k);
    chk("capped", capped, (k == MAXI) ? 1 : 0);
`endif
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_over", over, 1);
      chk("hold_ld", {ldsqrt, ldsum, ldval}, 0);
    end
    Go = 1'b0;
    @(negedge clk);
    idle_chk("ret");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; Go = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle_chk("rst");
`ifdef SQRT_SEQ_CTRL_STATUS_EN
    chk("rst_iter", iter, 0);
    chk("rst_capped", capped, 0);
`endif
    reset = 1'b1;
    @(negedge clk);
    idle_chk("idle");

    run(0, 0, -1);
    run(16, 0, -1);
    run(255, 0, -1);
    run(24, 30, -1);
    run(24, 0, -1);

    // reset pulled low mid-loop at E10
    n = 8'd200;
    @(negedge clk) Go = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    idle_chk("midrst");
    reset = 1'b1; Go = 1'b0;
    @(negedge clk);
    idle_chk("postrst");
    run(200, 0, -1);

    for (int r = 0; r < 10; r++) begin
      int nv, hold, drop;
      nv   = int'($urandom_range(0, 255));
      hold = int'($urandom_range(0, 3));
      drop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1;
      if (drop >= 0) hold = 0;
      run(nv, hold, drop);
    end
    run(224, 0, -1);
    run(225, 2, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sqrt_seq_ctrl.md
Name: sqrt_seq_ctrl

Overview:
- Clocked sequencer for the square-root datapath: the shared ALU with one-hot fnselect, plus sqrt/sum/val registers and X/Y bus selects.
- Runs the odd-number-sum algorithm: sqrt=0, val=1, sum=1; while n>=sum: sqrt++, val+=2, sum+=val.
- Each cycle it drives one ALU function, its bus selects and one load strobe. It consumes the B0 sign status and runs the Go/over handshake.
- An iteration cap guarantees termination and guards against sum wrap at full-scale n.

Parameters:
- WIDTH, 8, datapath width; must be even.
- MAX_ITER, 2**(WIDTH/2)-1, iteration cap (15 for WIDTH=8).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  reset, synchronous, active-low.
- Go  input  1  start request (level).
- B0  input  1  ALU sign status; 1 when n-sum<0; valid during COMPARE.
- over  output  1  result ready; sqrt register holds floor(sqrt(n)).
- busy  output  1  high in every state except IDLE and DONE.
- fnselect  output  6  one-hot ALU op: [0] zero, [1] x+y, [2] x-y, [3] const 1, [4] x+2, [5] y+1; all-zero when idle.
- TSW, Tval  output  1 each  X-bus source: n / val.
- Tsqrt, Tsum  output  1 each  Y-bus source: sqrt / sum.
- ldsqrt, ldsum, ldval  output  1 each  datapath register load enables, taken at the next clk edge.

Behaviour:
- Moore FSM with a registered state and iter_cnt (WIDTH/2 bits). All outputs decode combinationally from the state.
- Reset (reset==0 at an edge): state=IDLE, iter_cnt=0. Every output is 0 and fnselect=0. This holds from any state, including mid-run.
- At most one ld* and at most one X and one Y select are active in any state.
- Per-state outputs:
  - IDLE: all 0. Go=1 -> INIT_SQRT.
  - INIT_SQRT: fn[0], ldsqrt; iter_cnt<=0 -> INIT_VAL.
  - INIT_VAL: fn[3], ldval -> INIT_SUM.
  - INIT_SUM: fn[3], ldsum -> COMPARE.
  - COMPARE: fn[2], TSW, Tsum, no load. If B0==1 or iter_cnt==MAX_ITER -> DONE, else -> INC_SQRT.
  - INC_SQRT: fn[5], Tsqrt, ldsqrt -> INC_VAL.
  - INC_VAL: fn[4], Tval, ldval -> ADD_SUM.
  - ADD_SUM: fn[1], Tval, Tsum, ldsum; iter_cnt<=iter_cnt+1 -> COMPARE.
  - DONE: over=1, fnselect=0. Stays while Go=1; Go=0 -> IDLE.
- Latency: Go sampled at edge E0. over is high after edge E(4+4k), where k is the final sqrt value (k<=MAX_ITER).
- Cap: after MAX_ITER iterations sum=2**WIDTH wraps to 0, so B0 is meaningless. The cap check forces DONE with sqrt=MAX_ITER, which is correct for n>=MAX_ITER**2.
- Go dropping during busy is ignored; the run completes. A new run requires Go low, then high again.
- n must be stable from E0 to over. The block neither stores nor checks it.

Optional Feature:
- Macro: SQRT_SEQ_CTRL_STATUS_EN.
- Defined: adds output iter (WIDTH/2 bits), a copy of iter_cnt held stable in DONE. Also adds output capped (1 bit), set when DONE is entered through the cap rather than B0, cleared on INIT_SQRT and on reset. Both are 0 after reset.
- Undefined: neither port exists. iter_cnt remains internal and the cap behaviour is unchanged.

Test Plan:
- Reset low for 2 edges, then high; Go=0 -> all outputs 0, fnselect=0, busy=0, over=0.
- n=0, Go=1 at E0 -> fnselect sequence 000001, 001000, 001000, 000100; over=1 after E4; sqrt=0.
- n=16 -> four loops of 000100, 100000, 010000, 000010; over after E20; sqrt=4; ldsum pulses 5 times.
- n=255 -> B0 never 1 in COMPARE; cap exit; over after E64; sqrt=15; capped=1 when SQRT_SEQ_CTRL_STATUS_EN is defined.
- n=24: hold Go high for 30 cycles after over -> over stays 1, no ld* strobes. Drop Go -> IDLE next edge. Re-raise Go -> new run; sqrt=4.
- n=200: pull reset low at E10, mid-loop -> IDLE, outputs 0 on the next edge. A later Go runs cleanly; sqrt=14, over after E60.
